ldpc_3gpp_enc_p1_buf: RTL
=========================

# ldpc_3gpp_enc_p1_buf

Double-buffered receive store for the p1 parity stream of the 3GPP TS 38.212 LDPC encoder. It captures the write-once p1 word stream (write/wstart/wdat) produced after the inv(Psi) multiply. It then serves those words back, in order, to the p2 matrix-multiply stage through a request/valid read port. It decouples p1 production from p2 consumption so that p1 of frame N+1 can be written while p2 of frame N is still reading.

## Interface
Parameters:
- pADDR_W, 8, word-address width of one block row; max words per block row = 2^pADDR_W
- pDAT_W, 8, data word width (dat_t width)

Ports:
- iclk  in  1  clock
- ireset_n  in  1  reset, asynchronous, active-low
- iclkena  in  1  clock enable; all state frozen when low
- iused_zc  in  hb_zc_t  words per block row, legal 1..2^pADDR_W; sampled at iwstart and at read-frame start
- iwrite  in  1  write strobe
- iwstart  in  1  first word of p1 frame (qualified by iwrite)
- iwdat  in  dat_t  write word
- owready  out  1  at least one bank free
- iread  in  1  read request, one word per cycle
- oval  out  1  read data valid
- ostrb  out  strb_t  sof/eof of read frame; other fields 0
- orow  out  2  block-row index (0..3) of odat
- odat  out  dat_t  read word
- irelease  in  1  free the current read bank (macro-dependent, see Configuration)
- ofull  out  2  number of full banks (0..2)
- oerr  out  1  one-cycle error pulse
- ooverflow  out  1  sticky overflow flag, cleared only by reset

## Operation
- Frame = 4 block rows × iused_zc words = 4·iused_zc words. Bank address = {bank, row[1:0], word[pADDR_W-1:0]}.
- Write FSM: WIDLE → WFILL on iwrite&iwstart. In WFILL each iwrite stores one word and advances word/row counters. On the last word: the bank is marked full, the write bank toggles, and the FSM returns to WIDLE.
- iwrite&iwstart while in WFILL: partial frame discarded, restart at address 0 of the same bank, oerr pulse.
- iwrite without iwstart in WIDLE: word dropped, oerr pulse.
- iwrite&iwstart while ofull==2: frame dropped, ooverflow set, oerr pulse, stays WIDLE.
- Read FSM: RIDLE → RBUSY when ofull!=0. A word is issued per cycle with iread high; words are issued in address order. The first issued word carries sof; word 4·iused_zc−1 carries eof. After eof → RDONE.
- RDONE: bank released (see Configuration), read bank toggles, → RIDLE.
- iread in RIDLE/RDONE is ignored; no oval.
- Simultaneous write-complete and release in the same cycle: ofull unchanged (+1−1).
- owready = (ofull != 2).

## Timing
- Reset: oval=0, ostrb=0, orow=0, odat=0, ofull=0, oerr=0, ooverflow=0, owready=1, both FSMs idle, bank pointers=0.
- Write-to-full: ofull increments the cycle after the last word is written.
- Read latency: oval is 2 cycles after the accepted iread (1 RAM cycle + 1 output register). ostrb/orow/odat are aligned with oval.
- First read of a frame may be requested the cycle after ofull becomes non-zero.
- Same-bank read-while-write cannot occur; the banks are exclusive by construction.
- iclkena low: no counters advance; in-flight read pipeline holds its output.

## Configuration
- LDPC_3GPP_ENC_P1_BUF_REPLAY_EN defined: the bank is freed only on irelease in RDONE. While in RDONE without irelease, an iread restarts replay of the same bank from sof, so p2 can read p1 several times.
- Macro undefined: the bank is freed automatically the cycle after the eof word is issued, and irelease is ignored.

## Structure
- Shared encoder types package: dat_t, strb_t, hb_zc_t, and the bank address width constant (pADDR_W+3).
- One sub-module, ldpc_3gpp_enc_p1_buf_ram: simple dual-port RAM, depth 2^(pADDR_W+3), one write port, one registered read port, 1-cycle read latency.

## Test plan
- iused_zc=3, write 12 words 0..11 with iwstart on the first, then hold iread → odat 0..11; sof on word 0, eof on word 11; orow 0,0,0,1,…,3; oval 2 cycles after the first iread; ofull goes 1→0.
- Write two frames back-to-back with no reads → ofull=2 and owready=0. A third iwstart gives ooverflow=1 and one oerr pulse; reads return the first two frames intact.
- iwstart at word 5 of a frame → oerr pulse; the restarted 12-word frame is read back without the earlier partial data.
- Frame 2 completes in the same cycle as the frame-1 release → ofull stays 1, and the next read returns frame 2.
- REPLAY_EN: read a frame, hold off irelease, issue iread again → identical 12 words repeat; after irelease, ofull decrements. Without the macro, ofull drops after eof.
- Assert ireset_n mid-write and mid-read → all outputs take their reset values immediately; the next full frame is accepted normally.

Source files
------------

// File: rtl/ldpc_3gpp_enc_p1_buf_pkg.sv
// Shared types for the LDPC encoder p1 parity buffer: data word, strobe
// record, block-row size and bank address width.
package ldpc_3gpp_enc_p1_buf_pkg;

    localparam int cADDR_W = 8;
    localparam int cDAT_W  = 8;

    typedef logic [cDAT_W-1:0] dat_t;
    typedef logic [cADDR_W:0]  hb_zc_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } strb_t;

    localparam int cSTRB_W  = $bits(strb_t);
    localparam int cBADDR_W = cADDR_W + 3;

    // {bank, row[1:0], word[addr_w-1:0]}
    function automatic int bank_addr_w(input int addr_w);
        return addr_w + 3;
    endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_p1_buf_ram.sv
// Simple dual-port RAM for the p1 buffer: one write port, one registered
// read port with one cycle of latency.
module ldpc_3gpp_enc_p1_buf_ram
    import ldpc_3gpp_enc_p1_buf_pkg::*;
#(
    parameter int pADDR_W = cBADDR_W,
    parameter int pDAT_W  = cDAT_W
)(
    input  logic               iclk,
    input  logic               iwrite,
    input  logic [pADDR_W-1:0] iwaddr,
    input  logic [pDAT_W-1:0]  iwdat,
    input  logic               iread,
    input  logic [pADDR_W-1:0] iraddr,
    output logic [pDAT_W-1:0]  ordat
);

    logic [pDAT_W-1:0] mem [2**pADDR_W];

    // NOTE: neither the array nor its read register is reset, so the tools can map them onto block RAM.
    always_ff @(posedge iclk) begin
        if (iwrite) mem[iwaddr] <= iwdat;
        if (iread)  ordat       <= mem[iraddr];
    end

endmodule

// File: rtl/ldpc_3gpp_enc_p1_buf.sv
// Double-buffered p1 parity store between the inv(Psi) multiply and the p2 stage.
// Define LDPC_3GPP_ENC_P1_BUF_REPLAY_EN to hold a read bank until irelease (replay).
module ldpc_3gpp_enc_p1_buf
    import ldpc_3gpp_enc_p1_buf_pkg::*;
#(
    parameter int pADDR_W = cADDR_W,
    parameter int pDAT_W  = cDAT_W
)(
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic [pADDR_W:0]   iused_zc,
    input  logic               iwrite,
    input  logic               iwstart,
    input  logic [pDAT_W-1:0]  iwdat,
    output logic               owready,
    input  logic               iread,
    output logic               oval,
    output logic [cSTRB_W-1:0] ostrb,
    output logic [1:0]         orow,
    output logic [pDAT_W-1:0]  odat,
    input  logic               irelease,
    output logic [1:0]         ofull,
    output logic               oerr,
    output logic               ooverflow
);

    localparam int cBA_W = bank_addr_w(pADDR_W);

    localparam logic       cWIDLE = 1'b0;
    localparam logic       cWFILL = 1'b1;
    localparam logic [1:0] cRIDLE = 2'd0;
    localparam logic [1:0] cRBUSY = 2'd1;
    localparam logic [1:0] cRDONE = 2'd2;

    logic               wstate, wbank;
    logic [pADDR_W-1:0] wword;
    logic [1:0]         wrow;
    logic [pADDR_W:0]   wzc;

    logic [1:0]         rstate;
    logic               rbank;
    logic [pADDR_W-1:0] rword;
    logic [1:0]         rrow;
    logic [pADDR_W:0]   rzc;

    logic [1:0]         bank_full, w_set, r_clr;

    logic               w_start, w_new, w_restart, w_fill, w_over, w_drop, w_last, w_wrap;
    logic [pADDR_W-1:0] w_cur_word, w_nxt_word;
    logic [1:0]         w_cur_row, w_nxt_row;
    logic [pADDR_W:0]   w_cur_zc, w_zc_m1;

    logic               r_issue, r_replay, r_release, r_last, r_wrap;
    logic [pADDR_W-1:0] r_cur_word, r_nxt_word;
    logic [1:0]         r_cur_row, r_nxt_row;
    logic [pADDR_W:0]   r_zc_m1;
    strb_t              r_strb;

    logic               ram_we;
    logic [cBA_W-1:0]   ram_waddr, ram_raddr;
    logic [pDAT_W-1:0]  ram_q;

    logic               val1;
    strb_t              strb1;
    logic [1:0]         row1;

    assign ofull   = {bank_full[1] & bank_full[0], bank_full[1] ^ bank_full[0]};
    assign owready = ~(&bank_full);

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        w_start    = iclkena & iwrite & iwstart;
        w_new      = w_start & (wstate == cWIDLE) & ~(&bank_full);
        w_over     = w_start & (wstate == cWIDLE) & (&bank_full);
        w_restart  = w_start & (wstate == cWFILL);
        w_fill     = iclkena & iwrite & ~iwstart & (wstate == cWFILL);
        w_drop     = iclkena & iwrite & ~iwstart & (wstate == cWIDLE);
        // a (re)start writes word 0 of row 0 and advances using the fresh block-row size
        w_cur_word = w_start ? '0 : wword;
        w_cur_row  = w_start ? 2'd0 : wrow;
        w_cur_zc   = w_start ? iused_zc : wzc;
        w_zc_m1    = w_cur_zc - (pADDR_W+1)'(1);
        w_wrap     = ({1'b0, w_cur_word} == w_zc_m1);
        w_nxt_word = w_wrap ? '0 : w_cur_word + pADDR_W'(1);
        w_nxt_row  = w_wrap ? w_cur_row + 2'd1 : w_cur_row;
        w_last     = w_fill & w_wrap & (w_cur_row == 2'd3);
        w_set      = w_last ? (wbank ? 2'b10 : 2'b01) : 2'b00;
        ram_we     = w_new | w_restart | w_fill;
        ram_waddr  = {wbank, w_cur_row, w_cur_word};
    end

    // NOTE: sequential state is assigned only with non-blocking assignments.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            wstate    <= cWIDLE;
            wbank     <= 1'b0;
            wword     <= '0;
            wrow      <= 2'd0;
            wzc       <= '0;
            oerr      <= 1'b0;
            ooverflow <= 1'b0;
        end else if (iclkena) begin
            oerr <= w_over | w_drop | w_restart;
            if (w_over) ooverflow <= 1'b1;
            if (w_new | w_restart) begin
                wstate <= cWFILL;
                wzc    <= iused_zc;
                wword  <= w_nxt_word;
                wrow   <= w_nxt_row;
            end else if (w_fill) begin
                wword <= w_nxt_word;
                wrow  <= w_nxt_row;
                if (w_last) begin
                    wstate <= cWIDLE;
                    wbank  <= ~wbank;
                end
            end
        end
    end

`ifdef LDPC_3GPP_ENC_P1_BUF_REPLAY_EN
    assign r_replay  = iclkena & (rstate == cRDONE) & iread & ~irelease;
    assign r_release = iclkena & (rstate == cRDONE) & irelease;
`else
    logic unused_release;
    assign unused_release = irelease;
    assign r_replay       = 1'b0;
    assign r_release      = iclkena & (rstate == cRDONE);
`endif

    always_comb begin
        r_issue    = (iclkena & iread & (rstate == cRBUSY)) | r_replay;
        r_cur_word = r_replay ? '0 : rword;
        r_cur_row  = r_replay ? 2'd0 : rrow;
        r_zc_m1    = rzc - (pADDR_W+1)'(1);
        r_wrap     = ({1'b0, r_cur_word} == r_zc_m1);
        r_nxt_word = r_wrap ? '0 : r_cur_word + pADDR_W'(1);
        r_nxt_row  = r_wrap ? r_cur_row + 2'd1 : r_cur_row;
        r_last     = r_issue & r_wrap & (r_cur_row == 2'd3);
        r_strb     = '0;
        r_strb.sof = r_issue & (r_cur_word == '0) & (r_cur_row == 2'd0);
        r_strb.eof = r_last;
        r_clr      = r_release ? (rbank ? 2'b10 : 2'b01) : 2'b00;
        ram_raddr  = {rbank, r_cur_row, r_cur_word};
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            rstate <= cRIDLE;
            rbank  <= 1'b0;
            rword  <= '0;
            rrow   <= 2'd0;
            rzc    <= '0;
        end else if (iclkena) begin
            case (rstate)
                cRIDLE: if (bank_full[rbank]) begin
                    rstate <= cRBUSY;
                    rword  <= '0;
                    rrow   <= 2'd0;
                    rzc    <= iused_zc;
                end
                cRBUSY: if (r_issue) begin
                    rword <= r_nxt_word;
                    rrow  <= r_nxt_row;
                    if (r_last) rstate <= cRDONE;
                end
                cRDONE: if (r_release) begin
                    rbank  <= ~rbank;
                    rstate <= cRIDLE;
                end else if (r_replay) begin
                    rword  <= r_nxt_word;
                    rrow   <= r_nxt_row;
                    rstate <= cRBUSY;
                end
                default: rstate <= cRIDLE;
            endcase
        end
    end

    // write-complete and release always hit different banks, so +1-1 nets out here
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) bank_full <= 2'b00;
        else if (iclkena) bank_full <= (bank_full | w_set) & ~r_clr;
    end

    ldpc_3gpp_enc_p1_buf_ram #(
        .pADDR_W (cBA_W),
        .pDAT_W  (pDAT_W)
    ) u_ram (
        .iclk   (iclk),
        .iwrite (ram_we),
        .iwaddr (ram_waddr),
        .iwdat  (iwdat),
        .iread  (r_issue),
        .iraddr (ram_raddr),
        .ordat  (ram_q)
    );

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            val1  <= 1'b0;
            strb1 <= '0;
            row1  <= 2'd0;
            oval  <= 1'b0;
            ostrb <= '0;
            orow  <= 2'd0;
            odat  <= '0;
        end else if (iclkena) begin
            val1  <= r_issue;
            strb1 <= r_strb;
            row1  <= r_cur_row;
            oval  <= val1;
            ostrb <= val1 ? strb1 : '0;
            if (val1) begin
                orow <= row1;
                odat <= ram_q;
            end
        end
    end

endmodule
